// File: rtl/clock_mode_sequencer.sv
// Run/set/alarm-set mode sequencer for the digital clock: one-cycle increment strobes,
// beep flag and alarm ringing. Define SET_TIMEOUT_EN to abandon set mode after idle ticks.
module clock_mode_sequencer #(
   parameter int unsigned RING_SECONDS = 60,
   parameter int unsigned SET_TIMEOUT  = 30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1s,
   input  logic       set_pulse,
   input  logic       add_pulse,
   input  logic       beep_pulse,
   input  logic       time_match,
   output logic [2:0] cur_inc,
   output logic [2:0] alm_inc,
   output logic       carry_en,
   output logic       show_alarm,
   output logic [2:0] flash,
   output logic       beep_enabled,
   output logic       ringing
);

   localparam int unsigned RW = $clog2(RING_SECONDS + 1);

   typedef enum logic [6:0] {
      RUN      = 7'b0000001,
      SET_SEC  = 7'b0000010,
      SET_MIN  = 7'b0000100,
      SET_HOUR = 7'b0001000,
      ALM_SEC  = 7'b0010000,
      ALM_MIN  = 7'b0100000,
      ALM_HOUR = 7'b1000000
   } state_t;

   state_t        state, state_nxt;
   logic [2:0]    cur_nxt, alm_nxt, flash_nxt;
   logic          show_nxt;
   logic          tm_s, tm_d, tm_rise;
   logic [RW-1:0] ring_cnt, ring_cnt_nxt;
   logic          beep_nxt, ring_nxt;
   logic          timeout;

`ifdef SET_TIMEOUT_EN
   localparam int unsigned TW = $clog2(SET_TIMEOUT + 1);

   logic [TW-1:0] idle_cnt, idle_nxt;

   always_comb begin
      idle_nxt = idle_cnt;
      timeout  = 1'b0;
      if (state == RUN || set_pulse || add_pulse) begin
         idle_nxt = '0;
      end else if (tick_1s) begin
         if (idle_cnt + TW'(1) >= TW'(SET_TIMEOUT)) begin
            timeout  = 1'b1;
            idle_nxt = '0;
         end else begin
            idle_nxt = idle_cnt + TW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) idle_cnt <= '0;
      else      idle_cnt <= idle_nxt;
   end
`else
   assign timeout = 1'b0;
`endif

   // Mode sequencing and increment strobes; a simultaneous add wins over set.
   always_comb begin
      state_nxt = state;
      cur_nxt   = '0;
      alm_nxt   = '0;
      unique case (state)
         RUN:      cur_nxt[0] = tick_1s;
         SET_SEC:  cur_nxt[0] = add_pulse;
         SET_MIN:  cur_nxt[1] = add_pulse;
         SET_HOUR: cur_nxt[2] = add_pulse;
         ALM_SEC:  alm_nxt[0] = add_pulse;
         ALM_MIN:  alm_nxt[1] = add_pulse;
         ALM_HOUR: alm_nxt[2] = add_pulse;
         default:  ;
      endcase
      if (set_pulse && !add_pulse) begin
         unique case (state)
            RUN:      state_nxt = SET_SEC;
            SET_SEC:  state_nxt = SET_MIN;
            SET_MIN:  state_nxt = SET_HOUR;
            SET_HOUR: state_nxt = ALM_SEC;
            ALM_SEC:  state_nxt = ALM_MIN;
            ALM_MIN:  state_nxt = ALM_HOUR;
            default:  state_nxt = RUN;
         endcase
      end
      if (timeout) state_nxt = RUN;
   end

   always_comb begin
      flash_nxt = '0;
      show_nxt  = 1'b0;
      unique case (state_nxt)
         SET_SEC:  flash_nxt = 3'b001;
         SET_MIN:  flash_nxt = 3'b010;
         SET_HOUR: flash_nxt = 3'b100;
         ALM_SEC:  begin flash_nxt = 3'b001; show_nxt = 1'b1; end
         ALM_MIN:  begin flash_nxt = 3'b010; show_nxt = 1'b1; end
         ALM_HOUR: begin flash_nxt = 3'b100; show_nxt = 1'b1; end
         default:  ;
      endcase
   end

   assign tm_rise = tm_s & ~tm_d;

   // While ringing, beep_pulse silences instead of toggling the flag.
   always_comb begin
      beep_nxt     = beep_enabled;
      ring_nxt     = ringing;
      ring_cnt_nxt = ring_cnt;
      if (beep_pulse) begin
         if (ringing) ring_nxt = 1'b0;
         else         beep_nxt = ~beep_enabled;
      end else if (ringing && tick_1s) begin
         ring_cnt_nxt = ring_cnt + RW'(1);
         if (ring_cnt_nxt == RW'(RING_SECONDS)) ring_nxt = 1'b0;
      end
      if (tm_rise && state == RUN && beep_enabled && !beep_pulse) begin
         ring_nxt     = 1'b1;
         ring_cnt_nxt = '0;
      end
      if (state_nxt != RUN || !beep_nxt) ring_nxt = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= RUN;
         cur_inc      <= '0;
         alm_inc      <= '0;
         carry_en     <= 1'b1;
         show_alarm   <= 1'b0;
         flash        <= '0;
         beep_enabled <= 1'b0;
         ringing      <= 1'b0;
         ring_cnt     <= '0;
         tm_s         <= 1'b0;
         tm_d         <= 1'b0;
      end else begin
         state        <= state_nxt;
         cur_inc      <= cur_nxt;
         alm_inc      <= alm_nxt;
         carry_en     <= (state_nxt == RUN);
         show_alarm   <= show_nxt;
         flash        <= flash_nxt;
         beep_enabled <= beep_nxt;
         ringing      <= ring_nxt;
         ring_cnt     <= ring_cnt_nxt;
         tm_s         <= time_match;
         tm_d         <= tm_s;
      end
   end

endmodule

// File: tb/tb_clock_mode_sequencer.sv
// Scoreboard bench for clock_mode_sequencer (RING_SECONDS = 3, SET_TIMEOUT = 2).
module tb_clock_mode_sequencer;

   logic       clk = 1'b0;
   logic       rst, tick_1s, set_pulse, add_pulse, beep_pulse, time_match;
   logic [2:0] cur_inc, alm_inc, flash;
   logic       carry_en, show_alarm, beep_enabled, ringing;

   clock_mode_sequencer #(.RING_SECONDS(3), .SET_TIMEOUT(2)) dut (
      .clk(clk), .rst(rst), .tick_1s(tick_1s), .set_pulse(set_pulse),
      .add_pulse(add_pulse), .beep_pulse(beep_pulse), .time_match(time_match),
      .cur_inc(cur_inc), .alm_inc(alm_inc), .carry_en(carry_en),
      .show_alarm(show_alarm), .flash(flash), .beep_enabled(beep_enabled),
      .ringing(ringing)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         cyc;
      logic [6:0] v;
   } ev_t;

   ev_t        strobe_q[$];
   ev_t        stat_q[$];
   bit         mon_en = 1'b0;
   logic [6:0] prev_stat = 'x;
   bit         b = 1'b0;

   // {carry_en, show_alarm, flash} per state index: RUN, SET_SEC..SET_HOUR, ALM_SEC..ALM_HOUR
   logic [4:0] ST [7] = '{5'b10000, 5'b00001, 5'b00010, 5'b00100,
                          5'b01001, 5'b01010, 5'b01100};

   localparam logic [3:0] TICK = 4'b0001, SET = 4'b0010, ADD = 4'b0100, BEEP = 4'b1000;

   // Monitor: strobe events = {0, alm_inc, cur_inc} != 0; status events = any status change.
   always @(negedge clk) begin
      logic [6:0] s, st;
      ev_t        e;
      if (mon_en) begin
         s  = {1'b0, alm_inc, cur_inc};
         st = {carry_en, show_alarm, flash, beep_enabled, ringing};
         if (s != 7'd0) begin
            checks++;
            if (strobe_q.size() == 0) begin
               errors++;
               $display("FAIL strobe_unexpected cycle %0d: got %b, required none", cyc, s[5:0]);
            end else begin
               e = strobe_q.pop_front();
               if (e.v !== s || e.cyc != cyc) begin
                  errors++;
                  $display("FAIL strobe: got %b at cycle %0d, required %b at cycle %0d",
                           s[5:0], cyc, e.v[5:0], e.cyc);
               end
            end
         end
         if (st !== prev_stat) begin
            checks++;
            if (stat_q.size() == 0) begin
               errors++;
               $display("FAIL status_unexpected cycle %0d: got %b, required no change from %b",
                        cyc, st, prev_stat);
            end else begin
               e = stat_q.pop_front();
               if (e.v !== st || e.cyc != cyc) begin
                  errors++;
                  $display("FAIL status: got %b at cycle %0d, required %b at cycle %0d",
                           st, cyc, e.v, e.cyc);
               end
            end
         end
         prev_stat = st;
      end
   end

   task automatic exp_s(input int c, input logic [6:0] v);
      ev_t e;
      e.cyc = c;
      e.v   = v;
      strobe_q.push_back(e);
   endtask

   task automatic exp_t(input int c, input logic [6:0] v);
      ev_t e;
      e.cyc = c;
      e.v   = v;
      stat_q.push_back(e);
   endtask

   task automatic pulse(input logic [3:0] p);
      {beep_pulse, add_pulse, set_pulse, tick_1s} = p;
      @(posedge clk); #1;
      {beep_pulse, add_pulse, set_pulse, tick_1s} = '0;
      @(posedge clk); #1;
   endtask

   task automatic tm(input logic v);
      time_match = v;
      repeat (3) @(posedge clk);
      #1;
   endtask

   // n set pulses starting from state index 'from'; ringing assumed off.
   task automatic walk(input int from, input int n);
      int idx;
      for (int k = 0; k < n; k++) begin
         idx = (from + k + 1) % 7;
         exp_t(cyc + 1, {ST[idx], b, 1'b0});
         pulse(SET);
      end
   endtask

   initial begin
      rst = 1'b0;
      {beep_pulse, add_pulse, set_pulse, tick_1s} = '0;
      time_match = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      exp_t(cyc, 7'b1000000);
      mon_en = 1'b1;
      rst    = 1'b1;
      @(posedge clk); #1;

      // RUN: ticks advance seconds
      repeat (3) begin exp_s(cyc + 1, 7'b0000001); pulse(TICK); end

      // SET_MIN: adds bump minutes, tick frozen
      walk(0, 2);
      repeat (4) begin exp_s(cyc + 1, 7'b0000010); pulse(ADD); end
      pulse(TICK);

      // through to ALM_HOUR, add there, back to RUN, then a full loop
      walk(2, 4);
      exp_s(cyc + 1, 7'b0100000); pulse(ADD);
      walk(6, 1);
      walk(0, 7);

      // set+add together in SET_SEC: add wins, state kept
      walk(0, 1);
      exp_s(cyc + 1, 7'b0000001); pulse(SET | ADD);
      walk(1, 6);

      // arm, ring for 3 ticks, held match does not retrigger
      b = 1'b1;
      exp_t(cyc + 1, {ST[0], 2'b10}); pulse(BEEP);
      exp_t(cyc + 2, {ST[0], 2'b11}); tm(1'b1);
      repeat (2) begin exp_s(cyc + 1, 7'b0000001); pulse(TICK); end
      exp_s(cyc + 1, 7'b0000001);
      exp_t(cyc + 1, {ST[0], 2'b10}); pulse(TICK);
      exp_s(cyc + 1, 7'b0000001); pulse(TICK);
      tm(1'b0);

      // beep_pulse mid-ring silences, flag stays armed
      exp_t(cyc + 2, {ST[0], 2'b11}); tm(1'b1);
      exp_s(cyc + 1, 7'b0000001); pulse(TICK);
      exp_t(cyc + 1, {ST[0], 2'b10}); pulse(BEEP);
      tm(1'b0);

      // leaving RUN stops ringing
      exp_t(cyc + 2, {ST[0], 2'b11}); tm(1'b1);
      exp_t(cyc + 1, {ST[1], 2'b10}); pulse(SET);
      tm(1'b0);
      walk(1, 6);

      // disarm; a match then has no effect
      b = 1'b0;
      exp_t(cyc + 1, {ST[0], 2'b00}); pulse(BEEP);
      tm(1'b1);
      tm(1'b0);

      // idle ticks in SET_HOUR
      walk(0, 3);
      pulse(TICK);
`ifdef SET_TIMEOUT_EN
      exp_t(cyc + 1, {ST[0], 2'b00}); pulse(TICK);
      exp_s(cyc + 1, 7'b0000001); pulse(TICK);
`else
      pulse(TICK);
      pulse(TICK);
      walk(3, 4);
`endif

      // reset mid-operation drops the pending add strobe
      walk(0, 1);
      b = 1'b1;
      exp_t(cyc + 1, {ST[1], 2'b10}); pulse(BEEP);
      exp_t(cyc + 1, 7'b1000000);
      add_pulse = 1'b1;
      rst       = 1'b0;
      @(posedge clk); #1;
      add_pulse = 1'b0;
      rst       = 1'b1;
      b         = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      checks++;
      if (strobe_q.size() != 0) begin
         errors++;
         $display("FAIL strobe_pending: got %0d unseen strobes, required 0", strobe_q.size());
      end
      checks++;
      if (stat_q.size() != 0) begin
         errors++;
         $display("FAIL status_pending: got %0d unseen status changes, required 0", stat_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
